// File: rtl/or1200_bus_arb_pkg.sv
// Shared types and constants for the OR1200 CPU bus arbiter: FSM states,
// grant encodings, bus widths and the default watchdog limit.
package or1200_bus_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int TAG_W = 4;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_ICPU = 2'b01;
    localparam logic [1:0] GRANT_DCPU = 2'b10;

    // Owner encoding presented on grant_o for a given FSM state.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            ST_GNT_I: grant_of = GRANT_ICPU;
            ST_GNT_D: grant_of = GRANT_DCPU;
            default:  grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/or1200_bus_arb_wdt.sv
// Transfer watchdog: cleared while the arbiter is idle, counts granted cycles
// that see no termination, and flags expiry on the LIMIT-th granted cycle.
module or1200_bus_arb_wdt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    input  logic i_active,
    output logic o_expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    // Granted-cycle counter; restarts from zero every time the bus goes idle.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Counter starts at 0 on the first granted cycle, so LIMIT-1 marks cycle LIMIT.
    assign o_expire = i_active && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/or1200_cpu_bus_arb.sv
// Two-master arbiter sharing one memory port between the instruction-fetch
// and data units. Round-robin on ties (dcpu first after reset), one idle
// bubble between grants. Optional transfer watchdog enabled by defining
// OR1200_BUS_ARB_TIMEOUT_EN.
module or1200_cpu_bus_arb
    import or1200_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    // instruction-fetch master
    input  logic             icpu_cycstb_i,
    input  logic [ADR_W-1:0] icpu_adr_i,
    input  logic [SEL_W-1:0] icpu_sel_i,
    input  logic [TAG_W-1:0] icpu_tag_i,
    output logic [DAT_W-1:0] icpu_dat_o,
    output logic [TAG_W-1:0] icpu_tag_o,
    output logic             icpu_ack_o,
    output logic             icpu_rty_o,
    output logic             icpu_err_o,
    // data master
    input  logic             dcpu_cycstb_i,
    input  logic             dcpu_we_i,
    input  logic [ADR_W-1:0] dcpu_adr_i,
    input  logic [SEL_W-1:0] dcpu_sel_i,
    input  logic [TAG_W-1:0] dcpu_tag_i,
    input  logic [DAT_W-1:0] dcpu_dat_i,
    output logic [DAT_W-1:0] dcpu_dat_o,
    output logic [TAG_W-1:0] dcpu_tag_o,
    output logic             dcpu_ack_o,
    output logic             dcpu_rty_o,
    output logic             dcpu_err_o,
    // shared memory port
    output logic             mem_cycstb_o,
    output logic             mem_we_o,
    output logic [ADR_W-1:0] mem_adr_o,
    output logic [SEL_W-1:0] mem_sel_o,
    output logic [TAG_W-1:0] mem_tag_o,
    output logic [DAT_W-1:0] mem_dat_o,
    input  logic [DAT_W-1:0] mem_dat_i,
    input  logic [TAG_W-1:0] mem_tag_i,
    input  logic             mem_ack_i,
    input  logic             mem_rty_i,
    input  logic             mem_err_i,
    output logic [1:0]       grant_o
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_dcpu;      // 1: dcpu owned the bus last, icpu wins the next tie
    logic       w_last_dcpu_nxt;
    logic       w_term;
    logic       w_expire;
    logic       w_granted;

    assign w_term    = mem_ack_i | mem_rty_i | mem_err_i;
    assign w_granted = (r_state != ST_IDLE);

`ifdef OR1200_BUS_ARB_TIMEOUT_EN
    or1200_bus_arb_wdt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == ST_IDLE),
        .i_count  (w_granted && !w_term),
        .i_active (w_granted),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_expire         = 1'b0;
`endif

    // State and round-robin history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_last_dcpu <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_dcpu <= w_last_dcpu_nxt;
        end
    end

    // Next-state: arbitrate from idle, release on termination, withdrawal or expiry.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_dcpu_nxt = r_last_dcpu;
        case (r_state)
            ST_IDLE: begin
                if (icpu_cycstb_i && dcpu_cycstb_i) begin
                    w_state_nxt = r_last_dcpu ? ST_GNT_I : ST_GNT_D;
                end else if (icpu_cycstb_i) begin
                    w_state_nxt = ST_GNT_I;
                end else if (dcpu_cycstb_i) begin
                    w_state_nxt = ST_GNT_D;
                end
                if (w_state_nxt != ST_IDLE) begin
                    w_last_dcpu_nxt = (w_state_nxt == ST_GNT_D);
                end
            end
            ST_GNT_I: begin
                if (!icpu_cycstb_i || w_term || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (!dcpu_cycstb_i || w_term || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output mux: owner's request drives the port, terminations go to the owner only.
    always_comb begin
        mem_cycstb_o = 1'b0;
        mem_we_o     = 1'b0;
        mem_adr_o    = '0;
        mem_sel_o    = '0;
        mem_tag_o    = '0;
        mem_dat_o    = '0;
        icpu_dat_o   = '0;
        icpu_tag_o   = '0;
        icpu_ack_o   = 1'b0;
        icpu_rty_o   = 1'b0;
        icpu_err_o   = 1'b0;
        dcpu_dat_o   = '0;
        dcpu_tag_o   = '0;
        dcpu_ack_o   = 1'b0;
        dcpu_rty_o   = 1'b0;
        dcpu_err_o   = 1'b0;
        case (r_state)
            ST_GNT_I: begin
                mem_cycstb_o = icpu_cycstb_i && !w_expire;
                mem_adr_o    = icpu_adr_i;
                mem_sel_o    = icpu_sel_i;
                mem_tag_o    = icpu_tag_i;
                icpu_dat_o   = mem_dat_i;
                icpu_tag_o   = mem_tag_i;
                icpu_ack_o   = icpu_cycstb_i && !w_expire && mem_ack_i;
                icpu_rty_o   = icpu_cycstb_i && !w_expire && mem_rty_i;
                icpu_err_o   = icpu_cycstb_i && (w_expire || mem_err_i);
            end
            ST_GNT_D: begin
                mem_cycstb_o = dcpu_cycstb_i && !w_expire;
                mem_we_o     = dcpu_we_i;
                mem_adr_o    = dcpu_adr_i;
                mem_sel_o    = dcpu_sel_i;
                mem_tag_o    = dcpu_tag_i;
                mem_dat_o    = dcpu_dat_i;
                dcpu_dat_o   = mem_dat_i;
                dcpu_tag_o   = mem_tag_i;
                dcpu_ack_o   = dcpu_cycstb_i && !w_expire && mem_ack_i;
                dcpu_rty_o   = dcpu_cycstb_i && !w_expire && mem_rty_i;
                dcpu_err_o   = dcpu_cycstb_i && (w_expire || mem_err_i);
            end
            default: ;
        endcase
    end

    assign grant_o = grant_of(r_state);

endmodule

// File: tb/tb_or1200_cpu_bus_arb.sv
// Directed self-checking bench for or1200_cpu_bus_arb. Expected values are
// hand-derived; the watchdog scenario follows OR1200_BUS_ARB_TIMEOUT_EN.
module tb_or1200_cpu_bus_arb;

    logic        clk;
    logic        rst;
    logic        icpu_cycstb_i;
    logic [31:0] icpu_adr_i;
    logic [3:0]  icpu_sel_i;
    logic [3:0]  icpu_tag_i;
    logic [31:0] icpu_dat_o;
    logic [3:0]  icpu_tag_o;
    logic        icpu_ack_o, icpu_rty_o, icpu_err_o;
    logic        dcpu_cycstb_i, dcpu_we_i;
    logic [31:0] dcpu_adr_i;
    logic [3:0]  dcpu_sel_i;
    logic [3:0]  dcpu_tag_i;
    logic [31:0] dcpu_dat_i;
    logic [31:0] dcpu_dat_o;
    logic [3:0]  dcpu_tag_o;
    logic        dcpu_ack_o, dcpu_rty_o, dcpu_err_o;
    logic        mem_cycstb_o, mem_we_o;
    logic [31:0] mem_adr_o;
    logic [3:0]  mem_sel_o;
    logic [3:0]  mem_tag_o;
    logic [31:0] mem_dat_o;
    logic [31:0] mem_dat_i;
    logic [3:0]  mem_tag_i;
    logic        mem_ack_i, mem_rty_i, mem_err_i;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    or1200_cpu_bus_arb #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icpu_cycstb_i (icpu_cycstb_i),
        .icpu_adr_i    (icpu_adr_i),
        .icpu_sel_i    (icpu_sel_i),
        .icpu_tag_i    (icpu_tag_i),
        .icpu_dat_o    (icpu_dat_o),
        .icpu_tag_o    (icpu_tag_o),
        .icpu_ack_o    (icpu_ack_o),
        .icpu_rty_o    (icpu_rty_o),
        .icpu_err_o    (icpu_err_o),
        .dcpu_cycstb_i (dcpu_cycstb_i),
        .dcpu_we_i     (dcpu_we_i),
        .dcpu_adr_i    (dcpu_adr_i),
        .dcpu_sel_i    (dcpu_sel_i),
        .dcpu_tag_i    (dcpu_tag_i),
        .dcpu_dat_i    (dcpu_dat_i),
        .dcpu_dat_o    (dcpu_dat_o),
        .dcpu_tag_o    (dcpu_tag_o),
        .dcpu_ack_o    (dcpu_ack_o),
        .dcpu_rty_o    (dcpu_rty_o),
        .dcpu_err_o    (dcpu_err_o),
        .mem_cycstb_o  (mem_cycstb_o),
        .mem_we_o      (mem_we_o),
        .mem_adr_o     (mem_adr_o),
        .mem_sel_o     (mem_sel_o),
        .mem_tag_o     (mem_tag_o),
        .mem_dat_o     (mem_dat_o),
        .mem_dat_i     (mem_dat_i),
        .mem_tag_i     (mem_tag_i),
        .mem_ack_i     (mem_ack_i),
        .mem_rty_i     (mem_rty_i),
        .mem_err_i     (mem_err_i),
        .grant_o       (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g [4];
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};

        rst = 1'b0;
        icpu_cycstb_i = 1'b0; icpu_adr_i = '0; icpu_sel_i = '0; icpu_tag_i = '0;
        dcpu_cycstb_i = 1'b0; dcpu_we_i = 1'b0; dcpu_adr_i = '0; dcpu_sel_i = '0;
        dcpu_tag_i = '0; dcpu_dat_i = '0;
        mem_dat_i = '0; mem_tag_i = '0; mem_ack_i = 1'b0; mem_rty_i = 1'b0; mem_err_i = 1'b0;

        // Reset state
        #2;
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_cycstb", 32'(mem_cycstb_o), 32'h0);
        check("rst_iack", 32'(icpu_ack_o), 32'h0);
        check("rst_derr", 32'(dcpu_err_o), 32'h0);
        #6 rst = 1'b1;

        // Terminations while idle are discarded
        next_cycle();
        mem_ack_i = 1'b1; mem_err_i = 1'b1;
        #1;
        check("idle_iack", 32'(icpu_ack_o), 32'h0);
        check("idle_derr", 32'(dcpu_err_o), 32'h0);
        next_cycle();
        mem_ack_i = 1'b0; mem_err_i = 1'b0;
        #1;
        check("idle_grant", 32'(grant_o), 32'h0);

        // icpu alone, ack two cycles after grant
        icpu_cycstb_i = 1'b1; icpu_adr_i = 32'h0000_0100; icpu_sel_i = 4'hF; icpu_tag_i = 4'h3;
        #1;
        check("i_pre_grant", 32'(grant_o), 32'h0);
        check("i_pre_cycstb", 32'(mem_cycstb_o), 32'h0);
        next_cycle(); #1;
        check("i_grant", 32'(grant_o), 32'h1);
        check("i_cycstb", 32'(mem_cycstb_o), 32'h1);
        check("i_adr", mem_adr_o, 32'h0000_0100);
        check("i_tag", 32'(mem_tag_o), 32'h3);
        check("i_we", 32'(mem_we_o), 32'h0);
        next_cycle(); #1;
        check("i_wait_ack", 32'(icpu_ack_o), 32'h0);
        next_cycle();
        mem_ack_i = 1'b1; mem_dat_i = 32'hCAFE_0001; mem_tag_i = 4'h5;
        #1;
        check("i_ack", 32'(icpu_ack_o), 32'h1);
        check("i_dat", icpu_dat_o, 32'hCAFE_0001);
        check("i_rtag", 32'(icpu_tag_o), 32'h5);
        check("i_dack", 32'(dcpu_ack_o), 32'h0);
        check("i_ddat", dcpu_dat_o, 32'h0);
        next_cycle();
        mem_ack_i = 1'b0; icpu_cycstb_i = 1'b0;
        #1;
        check("i_done_grant", 32'(grant_o), 32'h0);
        check("i_done_ack", 32'(icpu_ack_o), 32'h0);

        // dcpu write, retry termination
        dcpu_cycstb_i = 1'b1; dcpu_we_i = 1'b1; dcpu_adr_i = 32'h0000_2000;
        dcpu_dat_i = 32'hDEAD_BEEF; dcpu_sel_i = 4'h3;
        next_cycle(); #1;
        check("d_grant", 32'(grant_o), 32'h2);
        check("d_we", 32'(mem_we_o), 32'h1);
        check("d_dat", mem_dat_o, 32'hDEAD_BEEF);
        check("d_adr", mem_adr_o, 32'h0000_2000);
        check("d_sel", 32'(mem_sel_o), 32'h3);
        mem_rty_i = 1'b1;
        #1;
        check("d_rty", 32'(dcpu_rty_o), 32'h1);
        check("d_irty", 32'(icpu_rty_o), 32'h0);
        check("d_ack_on_rty", 32'(dcpu_ack_o), 32'h0);
        next_cycle();
        mem_rty_i = 1'b0; dcpu_cycstb_i = 1'b0; dcpu_we_i = 1'b0;
        #1;
        check("d_done_grant", 32'(grant_o), 32'h0);

        // Round-robin after a fresh reset: D, I, D, I with a bubble between
        rst = 1'b0; #1 rst = 1'b1;
        icpu_cycstb_i = 1'b1; icpu_adr_i = 32'h0000_0100;
        dcpu_cycstb_i = 1'b1; dcpu_adr_i = 32'h0000_2000; dcpu_we_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            check("rr_grant", 32'(grant_o), 32'(exp_g[i]));
            check("rr_adr", mem_adr_o, (exp_g[i] == 2'b10) ? 32'h0000_2000 : 32'h0000_0100);
            check("rr_we", 32'(mem_we_o), (exp_g[i] == 2'b10) ? 32'h1 : 32'h0);
            mem_ack_i = 1'b1;
            #1;
            check("rr_iack", 32'(icpu_ack_o), (exp_g[i] == 2'b01) ? 32'h1 : 32'h0);
            check("rr_dack", 32'(dcpu_ack_o), (exp_g[i] == 2'b10) ? 32'h1 : 32'h0);
            next_cycle();
            mem_ack_i = 1'b0;
            #1;
            check("rr_bubble", 32'(grant_o), 32'h0);
            check("rr_bubble_cyc", 32'(mem_cycstb_o), 32'h0);
        end
        dcpu_cycstb_i = 1'b0; dcpu_we_i = 1'b0;

        // icpu withdraws one cycle after grant while ack arrives
        next_cycle(); #1;
        check("wd_grant", 32'(grant_o), 32'h1);
        next_cycle();
        icpu_cycstb_i = 1'b0; mem_ack_i = 1'b1;
        #1;
        check("wd_iack", 32'(icpu_ack_o), 32'h0);
        check("wd_cycstb", 32'(mem_cycstb_o), 32'h0);
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("wd_idle", 32'(grant_o), 32'h0);

        // dcpu error termination
        dcpu_cycstb_i = 1'b1;
        next_cycle(); #1;
        check("e_grant", 32'(grant_o), 32'h2);
        mem_err_i = 1'b1;
        #1;
        check("e_derr", 32'(dcpu_err_o), 32'h1);
        check("e_ierr", 32'(icpu_err_o), 32'h0);
        next_cycle();
        mem_err_i = 1'b0;
        #1;
        check("e_idle", 32'(grant_o), 32'h0);

        // Long transfer without termination
`ifdef OR1200_BUS_ARB_TIMEOUT_EN
        for (int n = 1; n <= 8; n++) begin
            next_cycle(); #1;
            check("to_grant", 32'(grant_o), 32'h2);
            check("to_derr", 32'(dcpu_err_o), (n == 8) ? 32'h1 : 32'h0);
            check("to_cycstb", 32'(mem_cycstb_o), (n == 8) ? 32'h0 : 32'h1);
        end
        next_cycle(); #1;
        check("to_idle", 32'(grant_o), 32'h0);
        dcpu_cycstb_i = 1'b0;
`else
        repeat (20) next_cycle();
        #1;
        check("hold_grant", 32'(grant_o), 32'h2);
        check("hold_derr", 32'(dcpu_err_o), 32'h0);
        check("hold_cycstb", 32'(mem_cycstb_o), 32'h1);
        dcpu_cycstb_i = 1'b0;
        next_cycle(); #1;
        check("hold_release", 32'(grant_o), 32'h0);
`endif

        // Asynchronous reset during GNT_D
        next_cycle();
        dcpu_cycstb_i = 1'b1;
        next_cycle(); #1;
        check("ar_grant", 32'(grant_o), 32'h2);
        check("ar_cycstb", 32'(mem_cycstb_o), 32'h1);
        #1;
        rst = 1'b0; mem_ack_i = 1'b1;
        #1;
        check("ar_rst_cycstb", 32'(mem_cycstb_o), 32'h0);
        check("ar_rst_grant", 32'(grant_o), 32'h0);
        check("ar_rst_dack", 32'(dcpu_ack_o), 32'h0);
        check("ar_rst_iack", 32'(icpu_ack_o), 32'h0);
        #1;
        rst = 1'b1; mem_ack_i = 1'b0; dcpu_cycstb_i = 1'b0;
        next_cycle(); #1;
        check("ar_after", 32'(grant_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
